plot_rx_framebuffer: RTL and testbench



---
 rtl/plot_rx_framebuffer.sv | 163 ++++++++++++++++
 tb/tb_plot_rx_framebuffer.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/plot_rx_framebuffer.sv
// Pixel-plot receiver: captures vga_* plots into a WIDTH x HEIGHT x 3 framebuffer, bulk-clears it,
// and replays it in raster order over valid/ready. Define PLOT_RX_SCAN_SUM_EN to enable scan_sum.
module plot_rx_framebuffer #(
   parameter int unsigned WIDTH        = 160,
   parameter int unsigned HEIGHT       = 120,
   parameter logic [2:0]  CLEAR_COLOUR = 3'b000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  vga_x,
   input  logic [6:0]  vga_y,
   input  logic [2:0]  vga_colour,
   input  logic        vga_plot,
   input  logic        clear_start,
   input  logic        scan_start,
   output logic        busy,
   output logic        scan_done,
   output logic        pix_valid,
   input  logic        pix_ready,
   output logic [7:0]  pix_x,
   output logic [6:0]  pix_y,
   output logic [2:0]  pix_colour,
   output logic [14:0] plot_count,
   output logic        range_err,
   output logic        drop_err,
   output logic [17:0] scan_sum
);
   // state | meaning
   // IDLE  | accept plots, wait for clear_start / scan_start
   // CLEAR | write CLEAR_COLOUR to one address per cycle; plots dropped
   // SCAN  | stream buffer out in raster order; plots still accepted
   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] CLEAR = 2'd1;
   localparam logic [1:0] SCAN  = 2'd2;

   localparam int unsigned NPIX      = WIDTH * HEIGHT;
   localparam logic [14:0] LAST_ADDR = 15'(NPIX - 1);
   localparam logic [7:0]  LAST_X    = 8'(WIDTH - 1);
   localparam logic [6:0]  LAST_Y    = 7'(HEIGHT - 1);

   logic [1:0]  state;
   logic [2:0]  mem [0:NPIX-1];
   logic [2:0]  rd_data;
   logic [14:0] faddr;
   logic [7:0]  fx;
   logic [6:0]  fy;
   logic        fetch_done;

   logic        in_range, plot_ok, plot_bad, plot_drop;
   logic        load, fetch, xfer, last_xfer;
   logic        we;
   logic [14:0] plot_addr, waddr;
   logic [2:0]  wdata;

   assign in_range  = (vga_x <= LAST_X) && (vga_y <= LAST_Y);
   assign plot_ok   = vga_plot && in_range && (state != CLEAR);
   assign plot_bad  = vga_plot && !in_range && (state != CLEAR);
   assign plot_drop = vga_plot && (state == CLEAR);
   assign plot_addr = 15'(vga_y) * 15'(WIDTH) + 15'(vga_x);

   // CLEAR and plots never write in the same cycle, so one write port suffices
   assign we    = (state == CLEAR) || plot_ok;
   assign waddr = (state == CLEAR) ? faddr : plot_addr;
   assign wdata = (state == CLEAR) ? CLEAR_COLOUR : vga_colour;

   // The read register doubles as the output stage: it only reloads when the
   // output slot is free or being drained, which gives 1 pixel/cycle and stall hold.
   assign load      = !pix_valid || pix_ready;
   assign fetch     = (state == SCAN) && load && !fetch_done;
   assign xfer      = pix_valid && pix_ready;
   assign last_xfer = xfer && (pix_x == LAST_X) && (pix_y == LAST_Y);

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   always_ff @(posedge clk) begin
      if (fetch) rd_data <= mem[faddr];
   end

   assign pix_colour = pix_valid ? rd_data : 3'b000;
   assign busy       = (state != IDLE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         faddr      <= '0;
         fx         <= '0;
         fy         <= '0;
         fetch_done <= 1'b0;
         pix_valid  <= 1'b0;
         pix_x      <= '0;
         pix_y      <= '0;
         scan_done  <= 1'b0;
      end else begin
         scan_done <= 1'b0;
         case (state)
            IDLE: begin
               faddr      <= '0;
               fx         <= '0;
               fy         <= '0;
               fetch_done <= 1'b0;
               if (clear_start)     state <= CLEAR;
               else if (scan_start) state <= SCAN;
            end
            CLEAR: begin
               faddr <= faddr + 15'd1;
               if (faddr == LAST_ADDR) state <= IDLE;
            end
            SCAN: begin
               if (load) begin
                  pix_valid <= fetch;
                  if (fetch) begin
                     pix_x      <= fx;
                     pix_y      <= fy;
                     faddr      <= faddr + 15'd1;
                     fetch_done <= (faddr == LAST_ADDR);
                     if (fx == LAST_X) begin
                        fx <= '0;
                        fy <= fy + 7'd1;
                     end else begin
                        fx <= fx + 8'd1;
                     end
                  end
               end
               if (last_xfer) begin
                  state     <= IDLE;
                  scan_done <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         plot_count <= '0;
         range_err  <= 1'b0;
         drop_err   <= 1'b0;
      end else begin
         if (state == IDLE && clear_start) begin
            plot_count <= '0;
            range_err  <= 1'b0;
         end else begin
            if (plot_ok && plot_count != 15'h7fff) plot_count <= plot_count + 15'd1;
            if (plot_bad) range_err <= 1'b1;
         end
         if (plot_drop) drop_err <= 1'b1;
      end
   end

`ifdef PLOT_RX_SCAN_SUM_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                                          scan_sum <= '0;
      else if (state == IDLE && scan_start && !clear_start) scan_sum <= '0;
      else if (xfer)                                    scan_sum <= scan_sum + 18'(pix_colour);
   end
`else
   assign scan_sum = '0;
`endif

endmodule

// File: tb/tb_plot_rx_framebuffer.sv
// Directed bench for plot_rx_framebuffer: clear, plots, stalled and full-rate scans, async abort.
module tb_plot_rx_framebuffer;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [7:0]  vga_x = '0;
   logic [6:0]  vga_y = '0;
   logic [2:0]  vga_colour = '0;
   logic        vga_plot = 1'b0;
   logic        clear_start = 1'b0;
   logic        scan_start = 1'b0;
   logic        busy, scan_done, pix_valid;
   logic        pix_ready = 1'b0;
   logic [7:0]  pix_x;
   logic [6:0]  pix_y;
   logic [2:0]  pix_colour;
   logic [14:0] plot_count;
   logic        range_err, drop_err;
   logic [17:0] scan_sum;

   int total = 0;
   int bad   = 0;

`ifdef PLOT_RX_SCAN_SUM_EN
   localparam int EXP_SUM = 8;
`else
   localparam int EXP_SUM = 0;
`endif

   always #5 clk = ~clk;

   plot_rx_framebuffer dut (
      .clk(clk), .rst(rst),
      .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour), .vga_plot(vga_plot),
      .clear_start(clear_start), .scan_start(scan_start),
      .busy(busy), .scan_done(scan_done),
      .pix_valid(pix_valid), .pix_ready(pix_ready),
      .pix_x(pix_x), .pix_y(pix_y), .pix_colour(pix_colour),
      .plot_count(plot_count), .range_err(range_err), .drop_err(drop_err),
      .scan_sum(scan_sum)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Buffer image after the clear plus the two in-range plots
   function automatic logic [2:0] exp_col(input int idx);
      if (idx == 1125)  return 3'd5;
      if (idx == 19199) return 3'd3;
      return 3'd0;
   endfunction

   task automatic plot(input logic [7:0] x, input logic [6:0] y, input logic [2:0] c);
      vga_x = x; vga_y = y; vga_colour = c; vga_plot = 1'b1;
      tick();
      vga_plot = 1'b0;
   endtask

   task automatic run_scan(input bit rand_ready, input int abort_at);
      int idx = 0;
      int cyc = 0;
      int done_seen = 0;
      bit stalled = 1'b0;
      logic [6:0] py = '0;
      logic [7:0] px = '0;
      logic [2:0] pc = '0;
      scan_start = 1'b1;
      pix_ready  = 1'b0;
      tick();
      scan_start = 1'b0;
      chk("scan_busy", 32'(busy), 1);
      chk("scan_lat_c1", 32'(pix_valid), 0);
      tick();
      chk("scan_lat_c2", 32'(pix_valid), 1);
      while (idx < 19200 && cyc < 60000) begin
         if (idx == abort_at) begin
            rst = 1'b1;
            #1;
            chk("abort_out_a", {busy, scan_done, pix_valid, pix_x, pix_y, pix_colour}, 0);
            chk("abort_out_b", {plot_count, range_err, drop_err}, 0);
            chk("abort_sum", 32'(scan_sum), 0);
            repeat (3) begin
               tick();
               if (scan_done) done_seen++;
            end
            chk("abort_no_done", done_seen, 0);
            rst = 1'b0;
            pix_ready = 1'b0;
            tick();
            chk("abort_idle", {busy, pix_valid, scan_done}, 0);
            return;
         end
         pix_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
         if (scan_done) done_seen++;
         if (stalled)
            chk("stall_hold", {pix_valid, pix_y, pix_x, pix_colour}, {1'b1, py, px, pc});
         else if (pix_valid)
            chk("pixel", {pix_y, pix_x, pix_colour}, {7'(idx / 160), 8'(idx % 160), exp_col(idx)});
         stalled = pix_valid && !pix_ready;
         py = pix_y; px = pix_x; pc = pix_colour;
         if (pix_valid && pix_ready) idx++;
         tick();
         cyc++;
      end
      chk("scan_transfers", idx, 19200);
      chk("scan_done_early", done_seen, 0);
      if (!rand_ready) chk("throughput_cycles", cyc, 19200);
      chk("scan_done_pulse", {scan_done, pix_valid, busy}, 3'b100);
      chk("scan_sum", 32'(scan_sum), EXP_SUM);
      pix_ready = 1'b0;
      tick();
      chk("scan_done_once", 32'(scan_done), 0);
      chk("scan_sum_hold", 32'(scan_sum), EXP_SUM);
   endtask

   initial begin
      int cnt;
      int pv_cnt;
      tick();
      tick();
      chk("reset_a", {busy, scan_done, pix_valid, pix_x, pix_y, pix_colour}, 0);
      chk("reset_b", {plot_count, range_err, drop_err}, 0);
      chk("reset_sum", 32'(scan_sum), 0);
      rst = 1'b0;
      tick();

      // clear and scan requested together; a plot lands mid-clear on an already-cleared address
      clear_start = 1'b1;
      scan_start  = 1'b1;
      tick();
      clear_start = 1'b0;
      scan_start  = 1'b0;
      cnt = 0;
      pv_cnt = 0;
      while (busy && cnt < 20000) begin
         cnt++;
         vga_x = 8'd3; vga_y = 7'd0; vga_colour = 3'd7;
         vga_plot = (cnt == 10);
         if (pix_valid) pv_cnt++;
         tick();
      end
      vga_plot = 1'b0;
      chk("clear_cycles", cnt, 19200);
      chk("clear_no_scan", pv_cnt, 0);
      chk("drop_err", 32'(drop_err), 1);
      chk("clear_count", 32'(plot_count), 0);
      chk("clear_range", 32'(range_err), 0);
      tick();
      chk("scan_dropped", {busy, pix_valid}, 0);

      plot(8'd5, 7'd7, 3'b101);
      chk("count_1", 32'(plot_count), 1);
      plot(8'd159, 7'd119, 3'b011);
      chk("count_2", 32'(plot_count), 2);
      chk("range_clean", 32'(range_err), 0);
      plot(8'd160, 7'd0, 3'b111);
      chk("range_x", 32'(range_err), 1);
      chk("count_rx", 32'(plot_count), 2);
      plot(8'd0, 7'd120, 3'b110);
      chk("count_ry", 32'(plot_count), 2);

      run_scan(1'b1, -1);
      run_scan(1'b0, 500);
      run_scan(1'b0, -1);
      chk("final_count", 32'(plot_count), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
